// File: rtl/volume_level_ctrl_if.sv
// Sample/frame/level bus between the mic front end, the volume level controller and the bar pixel generator.
interface volume_level_ctrl_if #(
  parameter int SAMPLE_W = 12
);
  logic                sample_valid;
  logic [SAMPLE_W-1:0] mic_sample;
  logic                frame_begin;
  logic                freeze;
  logic [3:0]          volume_level;
  logic                level_update;
  logic [3:0]          peak_level;

  modport master (
    output sample_valid, mic_sample, frame_begin, freeze,
    input  volume_level, level_update, peak_level
  );

  modport slave (
    input  sample_valid, mic_sample, frame_begin, freeze,
    output volume_level, level_update, peak_level
  );
endinterface

// File: rtl/volume_level_ctrl.sv
// Windowed peak detector turning mic samples into a 4-bit volume level, loaded only at frame boundaries.
// Optional peak-hold marker with decay is enabled by defining VOLUME_PEAK_HOLD_EN.
module volume_level_ctrl #(
  parameter int SAMPLE_W       = 12,
  parameter int MID_CODE       = 2048,
  parameter int WINDOW_SAMPLES = 2000,
  parameter int DECAY_FRAMES   = 30
) (
  input logic                 clk,
  input logic                 reset,
  volume_level_ctrl_if.slave  bus
);

  localparam logic [SAMPLE_W:0] MID_V    = (SAMPLE_W+1)'(MID_CODE);
  localparam logic [SAMPLE_W:0] AMP_MAX  = (SAMPLE_W+1)'(2047);
  localparam logic [15:0]       CNT_LAST = 16'(WINDOW_SAMPLES - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACCUM   = 2'd1,
    PENDING = 2'd2
  } state_t;

  state_t      state;
  logic [10:0] win_max;
  logic [15:0] sample_cnt;
  logic [3:0]  pending;
  logic [3:0]  vol_q;
  logic        upd_q;
  logic [3:0]  peak_q;

  logic [SAMPLE_W:0] diff;
  logic [SAMPLE_W:0] mag;
  logic [10:0]       amp;
  logic [10:0]       cur_max;
  logic [3:0]        q_level;
  logic              win_end;
  logic              do_load;

  always_comb begin
    diff    = {1'b0, bus.mic_sample} - MID_V;
    mag     = diff[SAMPLE_W] ? (~diff + 1'b1) : diff;
    amp     = (mag > AMP_MAX) ? 11'd2047 : mag[10:0];
    cur_max = (amp > win_max) ? amp : win_max;
    // cur_max is 11 bits, so >>7 is already capped at 15
    q_level = cur_max[10:7];
    win_end = bus.sample_valid && (sample_cnt == CNT_LAST);
    do_load = (state == PENDING) && bus.frame_begin && !bus.freeze;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      win_max    <= '0;
      sample_cnt <= '0;
      pending    <= '0;
      vol_q      <= '0;
      upd_q      <= 1'b0;
    end else begin
      upd_q <= 1'b0;

      if (bus.sample_valid) begin
        if (win_end) begin
          win_max    <= '0;
          sample_cnt <= '0;
        end else begin
          win_max    <= cur_max;
          sample_cnt <= sample_cnt + 16'd1;
        end
      end

      if (do_load) begin
        vol_q <= pending;
        upd_q <= 1'b1;
        state <= ACCUM;
      end

      // A window end in the same cycle as a load wins the state, so the fresh value stays pending
      if (win_end) begin
        pending <= q_level;
        state   <= PENDING;
      end
    end
  end

`ifdef VOLUME_PEAK_HOLD_EN
  localparam logic [15:0] DECAY_LAST = 16'(DECAY_FRAMES - 1);

  logic [15:0] decay_cnt;
  logic [3:0]  floor_level;

  assign floor_level = do_load ? pending : vol_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      peak_q    <= '0;
      decay_cnt <= '0;
    end else if (do_load && (pending > peak_q)) begin
      peak_q    <= pending;
      decay_cnt <= '0;
    end else if (bus.frame_begin && !bus.freeze) begin
      if (decay_cnt == DECAY_LAST) begin
        decay_cnt <= '0;
        if (peak_q > floor_level) peak_q <= peak_q - 4'd1;
      end else begin
        decay_cnt <= decay_cnt + 16'd1;
      end
    end
  end
`else
  assign peak_q = '0;
`endif

  assign bus.volume_level = vol_q;
  assign bus.level_update = upd_q;
  assign bus.peak_level   = peak_q;

endmodule

// File: tb/tb_volume_level_ctrl.sv
// Directed self-checking bench for volume_level_ctrl with WINDOW_SAMPLES=4, DECAY_FRAMES=3.
module tb_volume_level_ctrl;

  logic clk;
  logic reset;
  int   errors = 0;
  int   checks = 0;

  volume_level_ctrl_if #(.SAMPLE_W(12)) bus ();

  volume_level_ctrl #(
    .SAMPLE_W       (12),
    .MID_CODE       (2048),
    .WINDOW_SAMPLES (4),
    .DECAY_FRAMES   (3)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [11:0] code);
    bus.sample_valid = 1'b1;
    bus.mic_sample   = code;
    tick();
    bus.sample_valid = 1'b0;
  endtask

  task automatic window4(input logic [11:0] a, input logic [11:0] b,
                         input logic [11:0] c, input logic [11:0] d);
    send(a); send(b); send(c); send(d);
  endtask

  task automatic frame();
    bus.frame_begin = 1'b1;
    tick();
    bus.frame_begin = 1'b0;
  endtask

  initial begin
    bus.sample_valid = 1'b0;
    bus.mic_sample   = 12'd2048;
    bus.frame_begin  = 1'b0;
    bus.freeze       = 1'b0;
    reset            = 1'b1;
    tick(); tick(); tick();
    chk("reset_vol", 16'(bus.volume_level), 16'd0);
    chk("reset_upd", 16'(bus.level_update), 16'd0);
    chk("reset_peak", 16'(bus.peak_level), 16'd0);
    reset = 1'b0;
    tick();

    // frame in IDLE does nothing
    frame();
    chk("idle_frame_upd", 16'(bus.level_update), 16'd0);

    // quiet window -> level 0 loaded with a pulse
    window4(12'd2048, 12'd2048, 12'd2048, 12'd2048);
    chk("quiet_preload_upd", 16'(bus.level_update), 16'd0);
    frame();
    chk("quiet_load_upd", 16'(bus.level_update), 16'd1);
    chk("quiet_load_vol", 16'(bus.volume_level), 16'd0);
    tick();
    chk("pulse_one_cycle", 16'(bus.level_update), 16'd0);
    frame();
    chk("accum_frame_upd", 16'(bus.level_update), 16'd0);

    // amp 952 -> level 7, held until frame
    window4(12'd2048, 12'd3000, 12'd2048, 12'd2048);
    chk("lvl7_before_frame", 16'(bus.volume_level), 16'd0);
    frame();
    chk("lvl7_upd", 16'(bus.level_update), 16'd1);
    chk("lvl7_vol", 16'(bus.volume_level), 16'd7);

    // code 0 -> amp 2048 saturated -> 15
    window4(12'd0, 12'd2048, 12'd2048, 12'd2048);
    frame();
    chk("sat_vol", 16'(bus.volume_level), 16'd15);

    // pending=7, then a level-3 window ending on the same cycle as frame_begin
    window4(12'd3000, 12'd2048, 12'd2048, 12'd2048);
    send(12'd2448); send(12'd2448); send(12'd2448);
    bus.sample_valid = 1'b1;
    bus.mic_sample   = 12'd2048;
    bus.frame_begin  = 1'b1;
    tick();
    bus.sample_valid = 1'b0;
    bus.frame_begin  = 1'b0;
    chk("simul_upd", 16'(bus.level_update), 16'd1);
    chk("simul_vol_old", 16'(bus.volume_level), 16'd7);
    frame();
    chk("simul_next_upd", 16'(bus.level_update), 16'd1);
    chk("simul_next_vol", 16'(bus.volume_level), 16'd3);

    // freeze across two windows (5 then 9) and three frames
    bus.freeze = 1'b1;
    window4(12'd2748, 12'd2048, 12'd2048, 12'd2048);
    frame();
    chk("frz_f1_upd", 16'(bus.level_update), 16'd0);
    chk("frz_f1_vol", 16'(bus.volume_level), 16'd3);
    window4(12'd2048, 12'd848, 12'd2048, 12'd2048);
    frame();
    chk("frz_f2_upd", 16'(bus.level_update), 16'd0);
    frame();
    chk("frz_f3_upd", 16'(bus.level_update), 16'd0);
    chk("frz_f3_vol", 16'(bus.volume_level), 16'd3);
    bus.freeze = 1'b0;
    tick();
    chk("unfrz_hold_vol", 16'(bus.volume_level), 16'd3);
    frame();
    chk("unfrz_upd", 16'(bus.level_update), 16'd1);
    chk("unfrz_vol", 16'(bus.volume_level), 16'd9);
    chk("peak_default_path", 16'(bus.peak_level), 16'd0);

    // reset mid-window discards the partial window
    send(12'd0); send(12'd0);
    reset = 1'b1;
    tick();
    chk("midrst_vol", 16'(bus.volume_level), 16'd0);
    reset = 1'b0;
    tick();
    frame();
    chk("midrst_idle_upd", 16'(bus.level_update), 16'd0);
    window4(12'd2304, 12'd2304, 12'd2304, 12'd2304);
    frame();
    chk("midrst_new_upd", 16'(bus.level_update), 16'd1);
    chk("midrst_new_vol", 16'(bus.volume_level), 16'd2);

`ifdef VOLUME_PEAK_HOLD_EN
    // load 12, then level-2 windows: peak drops by one every third frame down to 2
    window4(12'd3648, 12'd2048, 12'd2048, 12'd2048);
    frame();
    chk("peak_load12_vol", 16'(bus.volume_level), 16'd12);
    chk("peak_load12", 16'(bus.peak_level), 16'd12);
    for (int k = 1; k <= 33; k++) begin
      window4(12'd2304, 12'd2304, 12'd2304, 12'd2304);
      frame();
      chk("peak_decay", 16'(bus.peak_level), ((12 - k / 3) < 2) ? 16'd2 : 16'(12 - k / 3));
    end
`else
    window4(12'd3648, 12'd2048, 12'd2048, 12'd2048);
    frame();
    chk("nopeak_load12_vol", 16'(bus.volume_level), 16'd12);
    for (int k = 1; k <= 4; k++) begin
      window4(12'd2304, 12'd2304, 12'd2304, 12'd2304);
      frame();
      chk("nopeak_zero", 16'(bus.peak_level), 16'd0);
    end
    chk("nopeak_last_vol", 16'(bus.volume_level), 16'd2);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
